phantom_txn_sequencer: RTL

Parametrised launcher and monitor for NUM_CH AXI master example channels, each with an INIT_AXI_TXN / TXN_DONE / ERROR triple. It replaces the fixed four-channel "kick all masters after a delay" behaviour with a synthesizable sequencer. Channel count, start delay and timeout width are parameters. It supports a parallel or sequential launch mode, a per-channel enable mask, per-channel error and timeout capture, and an aggregate pass/fail verdict. It sits between a control register block (AXI-lite slave) and the master channels of a phantom_dummy-class IP.

---
 rtl/phantom_txn_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/phantom_txn_sequencer.sv
// Launches and monitors NUM_CH AXI master example channels. Channels can be launched in
// parallel or sequentially. Errors and timeouts are captured per channel, and the run ends in a pass/fail verdict.
module phantom_txn_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int START_DELAY = 25,
  parameter int TIMEOUT_W   = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 start,
  input  logic                 mode,
  input  logic [NUM_CH-1:0]    ch_enable,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic [NUM_CH-1:0]    init_axi_txn,
  input  logic [NUM_CH-1:0]    txn_done,
  input  logic [NUM_CH-1:0]    txn_error,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_CH-1:0]    err_mask,
  output logic [NUM_CH-1:0]    timeout_mask,
  output logic [CH_W-1:0]      cur_ch
);

  typedef enum logic [2:0] {IDLE, DELAY, LAUNCH, WAIT, FINISH} state_t;

  state_t               state;
  logic [DLY_W-1:0]     dly_cnt;
  logic [TIMEOUT_W-1:0] tcnt;
  logic [TIMEOUT_W-1:0] limit_q;
  logic                 mode_q;
  logic [NUM_CH-1:0]    en_q;
  logic [NUM_CH-1:0]    serviced;
  logic [NUM_CH-1:0]    pending;
  logic [NUM_CH-1:0]    done_prev;

  logic [NUM_CH-1:0]    complete;
  logic [NUM_CH-1:0]    timed;
  logic [NUM_CH-1:0]    pending_nx;
  logic [NUM_CH-1:0]    remaining;
  logic [NUM_CH-1:0]    next_hot;
  logic [CH_W-1:0]      next_idx;
  logic                 expired;

  // A completion is a fresh rising edge of txn_done on a channel whose init line is still up,
  // so a level left over from an earlier run never counts.
  always_comb begin
    complete   = txn_done & ~done_prev & init_axi_txn & pending;
    expired    = (limit_q != '0) && (tcnt >= limit_q - TIMEOUT_W'(1));
    timed      = expired ? (pending & ~complete) : '0;
    pending_nx = pending & ~complete & ~timed;
    remaining  = en_q & ~serviced;
  end

  // Lowest enabled channel not yet launched; scanning downward lets the lowest index win.
  always_comb begin
    next_idx = '0;
    next_hot = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (remaining[i]) begin
        next_idx    = CH_W'(i);
        next_hot    = '0;
        next_hot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state        <= IDLE;
      dly_cnt      <= '0;
      tcnt         <= '0;
      limit_q      <= '0;
      mode_q       <= 1'b0;
      en_q         <= '0;
      serviced     <= '0;
      pending      <= '0;
      done_prev    <= '0;
      init_axi_txn <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_mask     <= '0;
      timeout_mask <= '0;
      cur_ch       <= '0;
    end else begin
      done_prev <= txn_done;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q       <= mode;
            en_q         <= ch_enable;
            limit_q      <= timeout_limit;
            err_mask     <= '0;
            timeout_mask <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            busy         <= 1'b1;
            serviced     <= '0;
            dly_cnt      <= '0;
            cur_ch       <= '0;
            state        <= (START_DELAY == 0) ? LAUNCH : DELAY;
          end
        end
        DELAY: begin
          if (dly_cnt == DLY_W'(START_DELAY - 1)) begin
            state <= LAUNCH;
          end else begin
            dly_cnt <= dly_cnt + DLY_W'(1);
          end
        end
        LAUNCH: begin
          tcnt <= '0;
          if (en_q == '0) begin
            state <= FINISH;
          end else if (!mode_q) begin
            init_axi_txn <= en_q;
            pending      <= en_q;
            serviced     <= en_q;
            state        <= WAIT;
          end else begin
            init_axi_txn <= next_hot;
            pending      <= next_hot;
            serviced     <= serviced | next_hot;
            cur_ch       <= next_idx;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (tcnt != '1) begin
            tcnt <= tcnt + TIMEOUT_W'(1);
          end
          init_axi_txn <= init_axi_txn & pending_nx;
          pending      <= pending_nx;
          err_mask     <= err_mask | (complete & txn_error);
          timeout_mask <= timeout_mask | timed;
          if (pending_nx == '0) begin
            state <= (mode_q && (remaining != '0)) ? LAUNCH : FINISH;
          end
        end
        FINISH: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          pass   <= ((err_mask | timeout_mask) == '0);
          cur_ch <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
